// File: rtl/rf_writeback_queue.sv
// Writeback FIFO feeding the register_file write port, with optional pending-value
// forwarding to the two read lookups (compiled in when RF_WBQ_BYPASS_EN is defined).
`ifdef RF_WBQ_BYPASS_EN
module rf_wbq_fwd #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int PW    = 2
) (
  input  logic [DEPTH-1:0][AW-1:0]   addr_q,
  input  logic [DEPTH-1:0][XLEN-1:0] data_q,
  input  logic [DEPTH-1:0]           vld_q,
  input  logic [PW-1:0]              head,
  input  logic [AW-1:0]              ra,
  output logic                       hit,
  output logic [XLEN-1:0]            data
);
  logic [PW-1:0] idx;

  // Walk head->tail so the newest matching entry overrides older ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld_q[idx] && (addr_q[idx] == ra) && (ra != '0)) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
  end
endmodule
`endif

module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AW-1:0]             in_addr,
  input  logic [XLEN-1:0]           in_data,
  input  logic                      rf_stall,
  output logic [AW-1:0]             a3,
  output logic                      we3,
  output logic [XLEN-1:0]           wd3,
  input  logic [AW-1:0]             a1,
  input  logic [AW-1:0]             a2,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  output logic [XLEN-1:0]           fwd_data1,
  output logic [XLEN-1:0]           fwd_data2,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][AW-1:0]   addr_q;
  logic [DEPTH-1:0][XLEN-1:0] data_q;
  logic [DEPTH-1:0]           vld_q;
  logic [PW-1:0]              head, tail;
  logic [CW-1:0]              cnt_q;
  logic                       push, pop;

  assign in_ready = (cnt_q != CW'(DEPTH));
  // x0 writes complete the handshake but are never stored.
  assign push     = in_valid & in_ready & (in_addr != '0);
  assign we3      = (cnt_q != '0) & ~rf_stall;
  assign pop      = we3;
  assign a3       = vld_q[head] ? addr_q[head] : '0;
  assign wd3      = vld_q[head] ? data_q[head] : '0;
  assign count    = cnt_q;

  // Power-of-two DEPTH lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= in_addr;
        data_q[tail] <= in_data;
        vld_q[tail]  <= 1'b1;
        tail         <= tail + 1'b1;
      end
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef RF_WBQ_BYPASS_EN
  logic [1:0][AW-1:0]   ra;
  logic [1:0]           hit;
  logic [1:0][XLEN-1:0] fdat;

  assign ra = {a2, a1};

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    rf_wbq_fwd #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW), .PW(PW)) u_fwd (
      .addr_q (addr_q),
      .data_q (data_q),
      .vld_q  (vld_q),
      .head   (head),
      .ra     (ra[p]),
      .hit    (hit[p]),
      .data   (fdat[p])
    );
  end

  assign fwd_hit1  = hit[0];
  assign fwd_hit2  = hit[1];
  assign fwd_data1 = fdat[0];
  assign fwd_data2 = fdat[1];
`else
  logic unused_ra;
  assign unused_ra = ^{a1, a2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed vector table, queue-based reference model,
// randomized traffic, and a modelled register file fed by the write port.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
`ifdef RF_WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, rf_stall, we3;
  logic [AW-1:0]   in_addr, a3, a1, a2;
  logic [XLEN-1:0] in_data, wd3, fwd_data1, fwd_data2;
  logic            fwd_hit1, fwd_hit2;
  logic [$clog2(DEPTH):0] count;

  rf_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .rf_stall(rf_stall),
    .a3(a3), .we3(we3), .wd3(wd3), .a1(a1), .a2(a2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [XLEN-1:0] d; } ent_t;
  typedef struct {
    bit rn, v; logic [AW-1:0] ad; logic [XLEN-1:0] d; bit st; logic [AW-1:0] x1, x2;
    int cnt; bit rdy, we; logic [AW-1:0] a3; logic [XLEN-1:0] wd; bit h1; logic [XLEN-1:0] f1; bit h2;
  } vec_t;

  ent_t            q[$];
  logic [XLEN-1:0] rf_dut [32];
  logic [XLEN-1:0] rf_ref [32];
  logic [XLEN-1:0] wlog[$];
  int checks = 0, errors = 0, cyc = 0;

  // Register file stand-in plus a log of every value the DUT writes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && we3) begin
      rf_dut[a3] <= wd3;
      wlog.push_back(wd3);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit rn, v, input logic [AW-1:0] ad, input logic [XLEN-1:0] d,
                       input bit st, input logic [AW-1:0] x1, x2);
    rst_n = rn; in_valid = v; in_addr = ad; in_data = d; rf_stall = st; a1 = x1; a2 = x2;
  endtask

  // Newest pending value for a register, from the model queue.
  task automatic mlook(input logic [AW-1:0] ra, output bit h, output logic [XLEN-1:0] fd);
    h = 1'b0; fd = '0;
    if (ra != 0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a == ra) begin h = 1'b1; fd = q[i].d; break; end
    if (!BYP) begin h = 1'b0; fd = '0; end
  endtask

  task automatic mcheck();
    bit h; logic [XLEN-1:0] fd;
    int n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
    chk("we3", 64'(we3), 64'(n > 0 && !rf_stall));
    chk("a3", 64'(a3), n > 0 ? 64'(q[0].a) : 64'd0);
    chk("wd3", 64'(wd3), n > 0 ? 64'(q[0].d) : 64'd0);
    mlook(a1, h, fd);
    chk("fwd_hit1", 64'(fwd_hit1), 64'(h));
    chk("fwd_data1", 64'(fwd_data1), 64'(fd));
    mlook(a2, h, fd);
    chk("fwd_hit2", 64'(fwd_hit2), 64'(h));
    chk("fwd_data2", 64'(fwd_data2), 64'(fd));
  endtask

  // Model's view of the coming edge, then step to just past it.
  task automatic advance();
    bit rdy = (q.size() != DEPTH);
    bit wr  = (q.size() > 0) && !rf_stall;
    if (!rst_n) q.delete();
    else begin
      if (wr) begin rf_ref[q[0].a] = q[0].d; void'(q.pop_front()); end
      if (in_valid && rdy && in_addr != 0) q.push_back('{in_addr, in_data});
    end
    @(posedge clk); #1;
  endtask

  task automatic cycle(input bit rn, v, input logic [AW-1:0] ad, input logic [XLEN-1:0] d,
                       input bit st, input logic [AW-1:0] x1, x2);
    drive(rn, v, ad, d, st, x1, x2);
    @(negedge clk);
    mcheck();
    advance();
  endtask

  vec_t vec[26];
  logic [XLEN-1:0] exp_log[$];

  initial begin
    for (int i = 0; i < 32; i++) begin rf_dut[i] = '0; rf_ref[i] = '0; end
    //           rn v ad d  st x1 x2  cnt rdy we a3 wd  h1 f1 h2
    vec[0]  = '{1,1,4,5,  0,0,0,  0,1,0,0,0,   0,0,0};
    vec[1]  = '{1,0,0,0,  0,4,0,  1,1,1,4,5,   1,5,0};
    vec[2]  = '{1,0,0,0,  0,4,0,  0,1,0,0,0,   0,0,0};
    vec[3]  = '{1,1,1,10, 1,0,0,  0,1,0,0,0,   0,0,0};
    vec[4]  = '{1,1,2,11, 1,0,0,  1,1,0,1,10,  0,0,0};
    vec[5]  = '{1,1,3,12, 1,0,0,  2,1,0,1,10,  0,0,0};
    vec[6]  = '{1,1,4,13, 1,0,0,  3,1,0,1,10,  0,0,0};
    vec[7]  = '{1,1,5,14, 1,0,0,  4,0,0,1,10,  0,0,0};
    vec[8]  = '{1,0,0,0,  0,0,0,  4,0,1,1,10,  0,0,0};
    vec[9]  = '{1,0,0,0,  0,0,0,  3,1,1,2,11,  0,0,0};
    vec[10] = '{1,0,0,0,  0,0,0,  2,1,1,3,12,  0,0,0};
    vec[11] = '{1,0,0,0,  0,0,0,  1,1,1,4,13,  0,0,0};
    vec[12] = '{1,0,0,0,  0,0,0,  0,1,0,0,0,   0,0,0};
    vec[13] = '{1,1,0,99, 0,0,0,  0,1,0,0,0,   0,0,0};
    vec[14] = '{1,0,0,0,  0,0,0,  0,1,0,0,0,   0,0,0};
    vec[15] = '{1,1,7,1,  1,7,3,  0,1,0,0,0,   0,0,0};
    vec[16] = '{1,1,7,2,  1,7,3,  1,1,0,7,1,   1,1,0};
    vec[17] = '{1,0,0,0,  1,7,3,  2,1,0,7,1,   1,2,0};
    vec[18] = '{1,0,0,0,  0,7,3,  2,1,1,7,1,   1,2,0};
    vec[19] = '{1,0,0,0,  0,7,3,  1,1,1,7,2,   1,2,0};
    vec[20] = '{1,0,0,0,  0,7,3,  0,1,0,0,0,   0,0,0};
    vec[21] = '{1,1,8,21, 1,0,0,  0,1,0,0,0,   0,0,0};
    vec[22] = '{1,1,9,22, 1,0,0,  1,1,0,8,21,  0,0,0};
    vec[23] = '{1,1,10,23,1,0,0,  2,1,0,8,21,  0,0,0};
    vec[24] = '{0,1,11,24,0,0,0,  3,1,1,8,21,  0,0,0};
    vec[25] = '{1,0,0,0,  0,0,0,  0,1,0,0,0,   0,0,0};

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset count", 64'(count), 0);
    chk("reset in_ready", 64'(in_ready), 1);
    chk("reset we3", 64'(we3), 0);
    chk("reset a3/wd3", 64'({a3, wd3}), 0);
    chk("reset fwd", 64'({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2}), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      drive(vec[i].rn, vec[i].v, vec[i].ad, vec[i].d, vec[i].st, vec[i].x1, vec[i].x2);
      @(negedge clk);
      mcheck();
      chk($sformatf("vec%0d count", i), 64'(count), 64'(vec[i].cnt));
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vec[i].rdy));
      chk($sformatf("vec%0d we3", i), 64'(we3), 64'(vec[i].we));
      chk($sformatf("vec%0d a3", i), 64'(a3), 64'(vec[i].a3));
      chk($sformatf("vec%0d wd3", i), 64'(wd3), 64'(vec[i].wd));
      chk($sformatf("vec%0d fwd1", i), 64'({fwd_hit1, fwd_data1}),
          BYP ? 64'({vec[i].h1, vec[i].f1}) : 64'd0);
      chk($sformatf("vec%0d fwd_hit2", i), 64'(fwd_hit2), BYP ? 64'(vec[i].h2) : 64'd0);
      advance();
    end
    chk("single write reached file", 64'(rf_dut[4]), 64'd13);
    exp_log = '{5, 10, 11, 12, 13, 1, 2};
    chk("write log length", 64'(wlog.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < wlog.size(); i++)
      chk($sformatf("write log[%0d]", i), 64'(wlog[i]), 64'(exp_log[i]));
    chk("reset discards reg8", 64'(rf_dut[8]), 0);
    chk("reset discards reg10", 64'(rf_dut[10]), 0);

    // Back-to-back stream through the pointer wrap.
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, AW'(i % 31 + 1), 100 + i, 0, 0, 0);
      #3 chk($sformatf("stream count %0d", i), 64'(count), 1);
    end
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("stream writes", 64'(wlog.size()), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++)
      chk($sformatf("stream order %0d", i), 64'(wlog[i]), 64'(100 + i));

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 9) < 3), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0, AW'(i % 8), 0);

    for (int r = 0; r < 32; r++)
      chk($sformatf("file reg %0d", r), 64'(rf_dut[r]), 64'(rf_ref[r]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Write-side initiator for `register_file`. Accepts register writeback requests over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Drains one entry per clock into the file's `a3`/`we3`/`wd3` write port. Optionally forwards pending (not-yet-written) values to the two read-address lookups, so decode sees the newest value of a register before it lands in the file.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..8.
- `XLEN`, 32: data width; must match `register_file`.
- `AW`, 5: register address width.

- `clk`  in  1  rising-edge clock, shared with `register_file`.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  writeback request valid.
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `in_addr`  in  AW  destination register.
- `in_data`  in  XLEN  value to write.
- `rf_stall`  in  1  when 1, drain is suppressed this cycle.
- `a3`  out  AW  to `register_file.a3`.
- `we3`  out  1  to `register_file.we3`.
- `wd3`  out  XLEN  to `register_file.wd3`.
- `a1`, `a2`  in  AW each  read addresses, also applied to `register_file`.
- `fwd_hit1`, `fwd_hit2`  out  1 each  a pending entry targets `a1`/`a2`.
- `fwd_data1`, `fwd_data2`  out  XLEN each  newest pending value for `a1`/`a2`.
- `count`  out  clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- Push: a push happens at a rising edge when `in_valid & in_ready`. The entry is written at the tail, and the tail pointer wraps modulo DEPTH.
- `in_addr == 0` (x0): the handshake completes, but nothing is enqueued and `count` is unchanged.
- Head drive: the write-port outputs come combinationally from the head entry.
  - Non-empty: `we3 = !rf_stall`, `a3`/`wd3` = head address/data.
  - Empty: `we3 = 0`, `a3 = 0`, `wd3 = 0`.
  - `a3`/`wd3` show the head even while stalled.
- Pop: a pop happens at a rising edge when `we3 == 1`. The head pointer advances modulo DEPTH. `register_file` samples the same entry at that same edge.
- Simultaneous push and pop: both happen, and `count` is unchanged. When full, `in_ready = 0` even if a pop is occurring. There is no full-queue pass-through.
- Ordering: strict FIFO. Multiple pending writes to one register all drain in order, and the last one wins in the file.
- Forwarding (`fwd_*`) is purely combinational over the valid entries only.
  - Among valid entries matching `aN`, the one nearest the tail supplies `fwd_dataN`.
  - The head entry is included, even in the cycle it drains.
  - The incoming `in_*` request is not included.
  - `aN == 0` always gives `fwd_hitN = 0`.
  - No match gives `fwd_hitN = 0`, `fwd_dataN = 0`.

## Timing
- Reset: at a rising edge with `rst_n == 0`:
  - head, tail and count go to 0, and all entries become invalid;
  - outputs then read `count = 0`, `in_ready = 1`, `we3 = 0`, `a3 = 0`, `wd3 = 0`, `fwd_hit* = 0`, `fwd_data* = 0`.
- Reset mid-operation: pending entries are discarded and never written. A push or pop requested at the reset edge is ignored.
- Latency: with an empty queue and no stall, an entry pushed at edge k is presented with `we3 = 1` in cycle k..k+1 and written into the file at edge k+1.
- Throughput: one push and one pop per cycle sustained, with no bubbles.
- `rf_stall` held N cycles delays the drain by exactly N cycles. Entries are not lost, and pushes continue until full.
- Pointer wrap: after DEPTH pushes and pops the pointers return to 0 with no corruption.

## Configuration
- `RF_WBQ_BYPASS_EN` defined: the forwarding logic is compiled in and behaves as in Operation.
- Not defined: the forwarding comparators are removed.
  - `fwd_hit1`, `fwd_hit2`, `fwd_data1`, `fwd_data2` are tied to 0.
  - The ports remain present.
  - All other behaviour is identical.

## Test plan
- Single write: reset, then push (addr 4, data 5) with `rf_stall = 0`. Required: `we3 = 1`, `a3 = 4`, `wd3 = 5` for exactly one cycle; `register_file` `rd1 = 5` with `a1 = 4` after the next edge; `count` goes 0→1→0.
- Fill and stall: hold `rf_stall = 1` and push addr 1..4, data 10..13 (DEPTH = 4). Required: `count = 4`, `in_ready = 0`, fifth push not accepted; release the stall and the writes drain in order 10, 11, 12, 13 on consecutive cycles.
- x0 drop: push (addr 0, data 99). Required: handshake completes, `count` stays 0, `we3` never asserts.
- Forwarding newest: stall, then push (7, 1) and (7, 2), set `a1 = 7`, `a2 = 3`. Required: `fwd_hit1 = 1`, `fwd_data1 = 2`, `fwd_hit2 = 0`. Built without `RF_WBQ_BYPASS_EN`: all `fwd_*` read 0.
- Simultaneous push and pop with wrap: stream 10 back-to-back pushes, no stall. Required: `count` stays 1 after the first push, and the file receives all 10 values in order.
- Reset mid-operation: with 3 entries pending, assert `rst_n = 0` for one edge. Required: `count = 0`, `we3 = 0`, and none of the 3 values reach the file.
